gpio_bank_arbiter: RTL

- Time-shares one bank of bidirectional ICE_* pins among NUM_REQ requesters inside pipelinec_top's clock domain.
- Round-robin arbitration, a bounded hold time, and a forced turnaround gap with all output-enables low. The gap prevents two owners from back-to-back driving the pins.
- Also double-flop synchronises the pin inputs for all requesters.
- Sits between requester logic and the top-level tristate pin connections.

---
 rtl/gpio_bank_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gpio_bank_arbiter.sv
// Time-shares one bank of tristate pins among NUM_REQ requesters with round-robin grants,
// a bounded hold time and an all-OE-low turnaround gap; also synchronises pin readback.
//
// state | meaning
// IDLE  | no owner; arbitrate among asserted req
// OWN   | gnt one-hot; owner's req_out/req_oe slice drives the pins
// TURN  | all OE low for TURN_CYC cycles before the next arbitration
module gpio_bank_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int PIN_W    = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk_48p0,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PIN_W-1:0] req_out,
  input  logic [NUM_REQ*PIN_W-1:0] req_oe,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [PIN_W-1:0]         pin_out,
  output logic [PIN_W-1:0]         pin_oe,
  input  logic [PIN_W-1:0]         pin_in,
  output logic [PIN_W-1:0]         in_sync,
  output logic                     busy
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_PRE = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_LD  = TW'(TURN_CYC - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t               state;
  logic [LW-1:0]        last_owner;
  logic [HW-1:0]        hold_cnt;
  logic [TW-1:0]        turn_cnt;
  logic [PIN_W-1:0]     sync1;
  logic [2*NUM_REQ-1:0] rot;
  logic [LW-1:0]        win;
  logic                 found;
  int                   w;
  logic                 owner_req;
  logic                 other_req;
  logic                 preempt;

  // Rotate the request vector so bit 0 is the requester just after last_owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    w     = 0;
    rot   = {req, req} >> ({1'b0, last_owner} + 1'b1);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        w = int'(last_owner) + 1 + k;
        if (w >= NUM_REQ) w = w - NUM_REQ;
        win = LW'(w);
      end
    end
  end

  assign owner_req = |(req & gnt);
  assign other_req = |(req & ~gnt);
  // >= so a saturated holder yields on the first cycle someone else asks.
  assign preempt   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_PRE) && other_req;

  always_ff @(posedge clk_48p0 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      last_owner <= LAST_RST;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= OWN;
            busy       <= 1'b1;
            gnt        <= NUM_REQ'(1) << win;
            last_owner <= win;
            hold_cnt   <= '0;
          end
        end
        OWN: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req || preempt) begin
            state    <= TURN;
            gnt      <= '0;
            turn_cnt <= TURN_LD;
          end
        end
        TURN: begin
          if (turn_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Gated by the registered grant, so reset clears the pins without waiting for an edge.
  always_comb begin
    pin_out = '0;
    pin_oe  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        pin_out = pin_out | req_out[i*PIN_W +: PIN_W];
        pin_oe  = pin_oe  | req_oe[i*PIN_W +: PIN_W];
      end
    end
  end

  always_ff @(posedge clk_48p0 or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      in_sync <= '0;
    end else begin
      sync1   <= pin_in;
      in_sync <= sync1;
    end
  end

endmodule
